// File: rtl/keypad_col_debounce.sv
// Column conditioning for the keypad scanner: two-flop synchroniser, raw detect flag,
// and a consecutive-sample debouncer producing a stable column code with press/release pulses.
module keypad_col_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] col_raw_i,
    output logic             detect_o,
    output logic [WIDTH-1:0] col_clean_o,
    output logic             press_o,
    output logic             release_o,
    output logic             multi_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic             detect_q;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] clean_q, clean_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             multi_q, multi_d;
    logic [WIDTH-1:0] s;

    assign s = sync2_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            detect_q <= 1'b0;
        end else begin
            sync1_q  <= col_raw_i;
            sync2_q  <= sync1_q;
            detect_q <= |sync2_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            clean_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            multi_q   <= multi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        multi_d   = multi_q;
        case (state_q)
            IDLE: begin
                if (s != '0) begin
                    state_d = PRESS_WAIT;
                    cand_d  = s;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (s == '0) begin
                    state_d = IDLE;
                end else if (s != cand_q) begin
                    cand_d = s;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    clean_d = cand_q;
                    press_d = 1'b1;
                    // More than one bit set iff clearing the lowest set bit leaves something.
                    multi_d = ((cand_q & (cand_q - 1'b1)) != '0);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                // A different non-zero code while held is ignored; only a release is tracked.
                if (s == '0) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s != '0) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    clean_d   = '0;
                    multi_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cand_d  = '0;
                cnt_d   = '0;
                clean_d = '0;
                multi_d = 1'b0;
            end
        endcase
    end

    assign detect_o    = detect_q;
    assign col_clean_o = clean_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign multi_o     = multi_q;

endmodule

// File: tb/tb_keypad_col_debounce.sv
// Scoreboarded bench: a run-length model of the synchronised column stream predicts
// per-cycle outputs and press/release events; a negedge monitor checks them.
module tb_keypad_col_debounce;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int MAXC = 4096;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic [W-1:0] col_raw_i = '0;
    logic         detect_o;
    logic [W-1:0] col_clean_o;
    logic         press_o;
    logic         release_o;
    logic         multi_o;

    always #5 clk = ~clk;

    keypad_col_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .col_raw_i  (col_raw_i),
        .detect_o   (detect_o),
        .col_clean_o(col_clean_o),
        .press_o    (press_o),
        .release_o  (release_o),
        .multi_o    (multi_o)
    );

    typedef struct {
        int           due;
        bit           is_press;
        logic [W-1:0] code;
    } ev_t;

    ev_t          evq[$];
    bit           exp_det[MAXC];
    bit [W-1:0]   exp_clean[MAXC];
    bit           exp_multi[MAXC];

    int           n_vec = 0;
    int           n_err = 0;
    int           edge_cnt = 0;
    bit           mon_en = 1'b0;

    // Reference state: whether a key is accepted, its code, and the current run of identical samples.
    bit           m_held = 1'b0;
    logic [W-1:0] m_code = '0;
    logic [W-1:0] m_run_val = '0;
    int           m_run_len = 0;

    always @(posedge clk) edge_cnt++;

    function automatic int popc(input logic [W-1:0] v);
        int c = 0;
        for (int b = 0; b < W; b++) c += int'(v[b]);
        return c;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    // One synchronised sample s, evaluated by the debouncer at edge 'due'.
    task automatic model_sample(input logic [W-1:0] e, input int due);
        if (e == m_run_val) begin
            if (m_run_len < 1000) m_run_len++;
        end else begin
            m_run_val = e;
            m_run_len = 1;
        end
        if (!m_held && e != '0 && m_run_len == N) begin
            m_held = 1'b1;
            m_code = e;
            evq.push_back('{due: due, is_press: 1'b1, code: e});
        end else if (m_held && e == '0 && m_run_len == N) begin
            m_held = 1'b0;
            evq.push_back('{due: due, is_press: 1'b0, code: '0});
        end
        if (due < MAXC) begin
            exp_det[due]   = |e;
            exp_clean[due] = m_held ? m_code : '0;
            exp_multi[due] = m_held && (popc(m_code) > 1);
        end
    endtask

    // Drive one raw value ahead of the next rising edge; a raw value reaches the FSM two edges later.
    task automatic step(input logic [W-1:0] v, input bit rst);
        int j;
        @(negedge clk);
        #1;
        j = edge_cnt + 1;
        col_raw_i = v;
        if (rst) begin
            reset_i   = 1'b1;
            m_held    = 1'b0;
            m_code    = '0;
            m_run_val = '0;
            m_run_len = 0;
            for (int d = j; d <= j + 1; d++) begin
                if (d < MAXC) begin
                    exp_det[d]   = 1'b0;
                    exp_clean[d] = '0;
                    exp_multi[d] = 1'b0;
                end
            end
            while (evq.size() > 0 && evq[evq.size()-1].due >= j) void'(evq.pop_back());
            model_sample('0, j + 2);
        end else begin
            reset_i = 1'b0;
            model_sample(v, j + 2);
        end
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            int k;
            k = edge_cnt;
            if (k < MAXC) begin
                chk("detect", k, 32'(detect_o), 32'(exp_det[k]));
                chk("col_clean", k, 32'(col_clean_o), 32'(exp_clean[k]));
                chk("multi", k, 32'(multi_o), 32'(exp_multi[k]));
            end
            while (evq.size() > 0 && evq[0].due < k) begin
                chk(evq[0].is_press ? "missed_press" : "missed_release", k, 32'(0), 32'(1));
                void'(evq.pop_front());
            end
            if (press_o || release_o) begin
                if (evq.size() == 0 || evq[0].due != k) begin
                    chk("unexpected_pulse", k, {30'd0, press_o, release_o}, 32'(0));
                end else begin
                    chk("pulse_kind", k, {30'd0, press_o, release_o},
                        evq[0].is_press ? 32'd2 : 32'd1);
                    chk("pulse_code", k, 32'(col_clean_o), 32'(evq[0].code));
                    void'(evq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        int           len;
        bit           r;

        step('0, 1'b1);
        step('0, 1'b1);
        mon_en = 1'b1;
        hold('0, 3);

        // Reset in the middle of a press: no pulse, clean code stays zero.
        hold(4'b0010, 3);
        step(4'b0010, 1'b1);
        hold('0, 8);

        // Clean single-column press and release.
        hold(4'b0100, 10);
        hold('0, 8);

        // Press bounce never reaches N identical samples.
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        hold('0, 6);

        // Candidate change during the wait restarts the count.
        hold(4'b0001, 2);
        hold(4'b1000, 8);
        hold('0, 8);

        // Release bounce absorbed, then a single release.
        hold(4'b1000, 8);
        step(4'b0000, 1'b0);
        step(4'b1000, 1'b0);
        hold('0, 10);

        // Two columns: multi set while held, cleared on release.
        hold(4'b0011, 6);
        hold('0, 8);

        for (int seg = 0; seg < 300; seg++) begin
            v   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            len = $urandom_range(1, 7);
            r   = ($urandom_range(0, 99) == 0);
            step(v, r);
            hold(v, len - 1);
        end

        hold('0, 12);
        chk("leftover_events", edge_cnt, 32'(evq.size()), 32'(0));
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
